// File: rtl/video_pattern_gen.sv
// video_pattern_gen: registered RGB test-pattern source (quadrants, bars, checkerboard, bouncing box)
module video_pattern_gen #(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int BOX_SIZE    = 32,
  parameter int BOX_STEP    = 2,
  parameter int CHECK_SHIFT = 5
) (
  input  logic        pixclk,
  input  logic        rst_n,
  input  logic [1:0]  mode_i,
  input  logic [25:0] cntX,
  input  logic [25:0] cntY,
  output logic [7:0]  red,
  output logic [7:0]  green,
  output logic [7:0]  blue,
  output logic        frame_tick_o,
  output logic [7:0]  frame_cnt_o
);
  localparam logic [25:0] HA    = 26'(H_ACTIVE);
  localparam logic [25:0] VA    = 26'(V_ACTIVE);
  localparam logic [25:0] HX    = 26'(H_ACTIVE / 2);
  localparam logic [25:0] HY    = 26'(V_ACTIVE / 2);
  localparam logic [25:0] BS    = 26'(BOX_SIZE);
  localparam logic [25:0] ST    = 26'(BOX_STEP);
  localparam logic [25:0] X_MAX = 26'(H_ACTIVE - BOX_SIZE);
  localparam logic [25:0] Y_MAX = 26'(V_ACTIVE - BOX_SIZE);
  localparam int          BW    = H_ACTIVE / 8;
  localparam logic [23:0] BAR_RGB [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                          24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
  logic [1:0]  r_mode;
  logic [25:0] r_box_x, r_box_y;
  logic        r_dir_x, r_dir_y;
  logic [2:0]  w_bar;
  logic [23:0] w_quad, w_rgb;
  logic        w_active, w_chk, w_in_box, w_fe;
  logic [25:0] w_nx, w_ny;
  logic        w_ndx, w_ndy;
  assign w_active = cntX < HA && cntY < VA;
  assign w_fe     = cntX == 26'd0 && cntY == VA;
  assign w_quad   = cntY >= HY ? (cntX >= HX ? 24'hFFFFFF : 24'h0000FF)
                               : (cntX >= HX ? 24'h00FF00 : 24'hFF0000);
  assign w_chk    = cntX[CHECK_SHIFT] ^ cntY[CHECK_SHIFT];
  assign w_in_box = cntX >= r_box_x && cntX < r_box_x + BS && cntY >= r_box_y && cntY < r_box_y + BS;
  // Bar index by threshold comparison; the last bar absorbs any remainder pixels
  always_comb begin
    w_bar = 3'd0;
    for (int k = 1; k < 8; k++)
      if (cntX >= 26'(k * BW)) w_bar = 3'(k);
  end
  always_comb begin
    w_rgb = !w_active      ? 24'h000000 :
            r_mode == 2'd0 ? w_quad :
            r_mode == 2'd1 ? BAR_RGB[w_bar] :
            r_mode == 2'd2 ? (w_chk ? 24'h000000 : 24'hFFFFFF) :
                             (w_in_box ? 24'hFFFF00 : 24'h000080);
  end
  // dir = 1 means moving toward 0; clamping keeps the box fully on screen
  always_comb begin
    w_ndx = r_dir_x ? r_box_x > ST : r_box_x + ST >= X_MAX;
    w_ndy = r_dir_y ? r_box_y > ST : r_box_y + ST >= Y_MAX;
    w_nx  = r_dir_x ? (r_box_x <= ST ? 26'd0 : r_box_x - ST)
                    : (r_box_x + ST >= X_MAX ? X_MAX : r_box_x + ST);
    w_ny  = r_dir_y ? (r_box_y <= ST ? 26'd0 : r_box_y - ST)
                    : (r_box_y + ST >= Y_MAX ? Y_MAX : r_box_y + ST);
  end
  always_ff @(posedge pixclk) begin
    if (!rst_n) begin
      {red, green, blue} <= 24'h0;
      frame_tick_o       <= 1'b0;
      frame_cnt_o        <= 8'd0;
      r_mode             <= 2'd0;
      r_box_x            <= 26'd0;
      r_box_y            <= 26'd0;
      r_dir_x            <= 1'b0;
      r_dir_y            <= 1'b0;
    end else begin
      {red, green, blue} <= w_rgb;
      frame_tick_o       <= w_fe;
      if (w_fe) begin
        r_mode      <= mode_i;
        frame_cnt_o <= frame_cnt_o + 8'd1;
        r_box_x     <= w_nx;
        r_box_y     <= w_ny;
        r_dir_x     <= w_ndx;
        r_dir_y     <= w_ndy;
      end
    end
  end
endmodule

// File: tb/tb_video_pattern_gen.sv
// tb_video_pattern_gen: directed + random checks against an arithmetic reference model
module tb_video_pattern_gen;
  logic        pixclk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  mode_i = 2'd0;
  logic [25:0] cntX = 26'd0, cntY = 26'd0;
  logic [7:0]  red, green, blue, frame_cnt_o;
  logic        frame_tick_o;
  int          n_cmp = 0, n_bad = 0;
  int          m_n = 0;
  logic [1:0]  m_mode = 2'd0;
  logic [7:0]  m_fcnt = 8'd0;
  logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  video_pattern_gen dut (
    .pixclk(pixclk), .rst_n(rst_n), .mode_i(mode_i), .cntX(cntX), .cntY(cntY),
    .red(red), .green(green), .blue(blue),
    .frame_tick_o(frame_tick_o), .frame_cnt_o(frame_cnt_o)
  );

  always #5 pixclk = ~pixclk;

  // Box travel is a triangle wave: step count * step size folded into [0, limit]
  function automatic int tri_pos(input int steps, input int lim);
    int r = (steps * 2) % (2 * lim);
    return r <= lim ? r : 2 * lim - r;
  endfunction

  function automatic int box_x();
    return tri_pos(m_n, 640 - 32);
  endfunction

  function automatic int box_y();
    return tri_pos(m_n, 480 - 32);
  endfunction

  function automatic logic [23:0] exp_px(input int x, input int y);
    int k;
    if (x >= 640 || y >= 480) return 24'h000000;
    case (m_mode)
      2'd0: return (y < 240) ? (x < 320 ? 24'hFF0000 : 24'h00FF00)
                             : (x < 320 ? 24'h0000FF : 24'hFFFFFF);
      2'd1: begin
        k = x / 80;
        if (k > 7) k = 7;
        return bars[k];
      end
      2'd2: return ((x / 32 + y / 32) % 2 == 0) ? 24'hFFFFFF : 24'h000000;
      default: return (x >= box_x() && x < box_x() + 32 && y >= box_y() && y < box_y() + 32)
                      ? 24'hFFFF00 : 24'h000080;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic px(input int x, input int y, input string tag);
    logic [23:0] e;
    bit fe;
    cntX = 26'(x);
    cntY = 26'(y);
    e = exp_px(x, y);
    fe = (x == 0 && y == 480);
    @(posedge pixclk);
    #1;
    if (fe) begin
      m_mode = mode_i;
      m_n++;
      m_fcnt++;
    end
    chk({tag, "_rgb"}, {8'h0, red, green, blue}, {8'h0, e});
    chk({tag, "_tick"}, {31'h0, frame_tick_o}, {31'h0, fe});
    chk({tag, "_fcnt"}, {24'h0, frame_cnt_o}, {24'h0, m_fcnt});
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge pixclk);
    #1;
    m_n = 0;
    m_mode = 2'd0;
    m_fcnt = 8'd0;
    chk("rst_rgb", {8'h0, red, green, blue}, 32'h0);
    chk("rst_tick", {31'h0, frame_tick_o}, 32'h0);
    chk("rst_fcnt", {24'h0, frame_cnt_o}, 32'h0);
  endtask

  initial begin
    cntX = 26'd10;
    cntY = 26'd10;
    mode_i = 2'd1;
    repeat (3) do_reset();
    rst_n = 1'b1;
    mode_i = 2'd0;
    px(10, 10, "post_rst");
    px(319, 0, "q_r");
    px(320, 0, "q_g");
    px(0, 240, "q_b");
    px(320, 240, "q_w");
    px(640, 0, "q_hblank");
    px(0, 480, "vblank");
    px(67108863, 5, "oversize_x");
    px(5, 33554432, "oversize_y");
    mode_i = 2'd1;
    px(0, 100, "latch_mid");
    px(0, 200, "latch_still0");
    px(0, 480, "latch_event");
    px(85, 0, "bar1");
    for (int i = 0; i < 8; i++) begin
      px(i * 80, 7, "bar_lo");
      px(i * 80 + 79, 7, "bar_hi");
    end
    mode_i = 2'd2;
    px(0, 480, "to_chk");
    px(0, 0, "chk00");
    px(32, 0, "chk32_0");
    px(32, 32, "chk32_32");
    px(31, 63, "chk31_63");
    mode_i = 2'd3;
    for (int i = 0; i < 310; i++) begin
      px(0, 480, "bounce_ev");
      px(box_x(), box_y(), "box_in");
      px(box_x() + 32, box_y(), "box_right");
      px(box_x() + 31, box_y() + 31, "box_corner");
      px(box_x(), box_y() + 32, "box_below");
    end
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        mode_i = 2'($urandom_range(0, 3));
        px(0, 480, "rnd_ev");
      end else begin
        px($urandom_range(0, 700), $urandom_range(0, 520), "rnd_px");
      end
    end
    while (m_fcnt != 8'd0) px(0, 480, "wrap_ev");
    chk("wrap_zero", {24'h0, frame_cnt_o}, 32'h0);
    px(100, 300, "pre_rst_px");
    cntX = 26'd100;
    cntY = 26'd300;
    mode_i = 2'd3;
    do_reset();
    rst_n = 1'b1;
    px(0, 0, "mid_rst_px");
    px(0, 480, "mid_rst_ev");
    px(box_x(), box_y(), "mid_rst_box");
    px(0, 0, "mid_rst_origin");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
